// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the alu_seq issue controller.
// The reference function ref_alu is used only when ALU_SEQ_CHECK_EN is defined.
package alu_seq_pkg;

    localparam int W    = 16;
    localparam int NREG = 4;
    localparam int AW   = 2;

    localparam logic [2:0] OPC_NEG    = 3'b000;
    localparam logic [2:0] OPC_INC    = 3'b001;
    localparam logic [2:0] OPC_ADD    = 3'b010;
    localparam logic [2:0] OPC_ASR    = 3'b011;
    localparam logic [2:0] OPC_AND    = 3'b100;
    localparam logic [2:0] OPC_OR     = 3'b101;
    localparam logic [2:0] OPC_CONCAT = 3'b110;
    localparam logic [2:0] OPC_LOAD   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    // Expected ALU result, wrapping modulo 2^W
    function automatic logic [W-1:0] ref_alu(
        input logic [2:0]   opc,
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic         cin
    );
        logic [W-1:0] r;
        case (opc)
            OPC_NEG:    r = ~a + {{(W-1){1'b0}}, 1'b1};
            OPC_INC:    r = a + {{(W-1){1'b0}}, 1'b1};
            OPC_ADD:    r = a + b + {{(W-1){1'b0}}, cin};
            OPC_ASR:    r = a + {b[W-1], b[W-1:1]};
            OPC_AND:    r = a & b;
            OPC_OR:     r = a | b;
            OPC_CONCAT: r = {a[W/2-1:0], b[W/2-1:0]};
            default:    r = {W{1'b0}};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// 4x16 register file: one synchronous write port, two combinational operand
// read ports and a combinational debug read port; asynchronous clear to zero.
module alu_seq_regfile
    import alu_seq_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    input  logic [AW-1:0] dbg_addr,
    output logic [W-1:0]  rdata_a,
    output logic [W-1:0]  rdata_b,
    output logic [W-1:0]  dbg_data
);

    logic [W-1:0] mem_r [NREG];

    // Storage array with single write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata_a  = mem_r[raddr_a];
    assign rdata_b  = mem_r[raddr_b];
    assign dbg_data = mem_r[dbg_addr];

endmodule

// File: rtl/alu_seq.sv
// Issue controller for the 16-bit combinational ALU: accept, execute, respond.
// Optional ALU self-check is enabled by defining ALU_SEQ_CHECK_EN.
module alu_seq
    import alu_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [2:0]  instr_opc,
    input  logic [1:0]  instr_rd,
    input  logic [1:0]  instr_ra,
    input  logic [1:0]  instr_rb,
    input  logic        instr_cin,
    input  logic [15:0] instr_imm,
    output logic [2:0]  alu_opc,
    output logic [15:0] alu_ina,
    output logic [15:0] alu_inb,
    output logic        alu_inc,
    input  logic [15:0] alu_w,
    input  logic        alu_zer,
    input  logic        alu_neg,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_zer,
    output logic        rsp_neg,
    input  logic [1:0]  dbg_addr,
    output logic [15:0] dbg_data,
    output logic        err
);

    state_t        state_r;
    logic [AW-1:0] rd_r;
    logic [W-1:0]  imm_r;
    logic [W-1:0]  rf_a_s;
    logic [W-1:0]  rf_b_s;
    logic          is_load_s;
    logic          wr_en_s;
    logic [W-1:0]  wr_data_s;
    logic          wr_zer_s;
    logic          wr_neg_s;

    assign instr_ready = (state_r == IDLE) && rst_n;

    alu_seq_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (wr_en_s),
        .waddr    (rd_r),
        .wdata    (wr_data_s),
        .raddr_a  (instr_ra),
        .raddr_b  (instr_rb),
        .dbg_addr (dbg_addr),
        .rdata_a  (rf_a_s),
        .rdata_b  (rf_b_s),
        .dbg_data (dbg_data)
    );

    // Writeback selection: immediate for LOAD, ALU result otherwise
    always_comb begin
        is_load_s = (alu_opc == OPC_LOAD);
        wr_en_s   = (state_r == EXEC);
        if (is_load_s) begin
            wr_data_s = imm_r;
            wr_zer_s  = (imm_r == {W{1'b0}});
            wr_neg_s  = imm_r[W-1];
        end else begin
            wr_data_s = alu_w;
            wr_zer_s  = alu_zer;
            wr_neg_s  = alu_neg;
        end
    end

    // Control FSM with registered ALU drive and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            rd_r      <= {AW{1'b0}};
            imm_r     <= {W{1'b0}};
            alu_opc   <= 3'b000;
            alu_ina   <= {W{1'b0}};
            alu_inb   <= {W{1'b0}};
            alu_inc   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= {W{1'b0}};
            rsp_zer   <= 1'b0;
            rsp_neg   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (instr_valid && instr_ready) begin
                        alu_opc <= instr_opc;
                        alu_ina <= rf_a_s;
                        alu_inb <= rf_b_s;
                        alu_inc <= (instr_opc == OPC_ADD) ? instr_cin : 1'b0;
                        rd_r    <= instr_rd;
                        imm_r   <= instr_imm;
                        state_r <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= wr_data_s;
                    rsp_zer   <= wr_zer_s;
                    rsp_neg   <= wr_neg_s;
                    rsp_valid <= 1'b1;
                    state_r   <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_CHECK_EN
    logic [W-1:0] exp_w_s;
    logic         chk_fail_s;
    logic         err_r;

    // Compare the ALU against the reference for the operands it was given
    always_comb begin
        exp_w_s    = ref_alu(alu_opc, alu_ina, alu_inb, alu_inc);
        chk_fail_s = (alu_w != exp_w_s)
                  || (alu_zer != (exp_w_s == {W{1'b0}}))
                  || (alu_neg != exp_w_s[W-1]);
    end

    // Sticky error flag, sampled at the end of a non-LOAD execute cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if ((state_r == EXEC) && !is_load_s && chk_fail_s) begin
            err_r <= 1'b1;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Issuing-side controller for the team's 16-bit combinational ALU (opcodes 000–110; results w, zer, neg).
- Accepts one instruction at a time over a valid/ready handshake and reads operands from an internal 4x16 register file.
- Drives the ALU inputs from registers, captures the result, writes it back and returns it with flags over a valid/ready response channel.
- Sits between the instruction source and the ALU.

Parameters:
- NREG, 4, register-file depth; fixed power of two; index width log2(NREG)=2.
- W, 16, datapath width; must match the ALU.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction present
- instr_ready  out  1  high only in IDLE with rst_n high
- instr_opc  in  3  000 neg, 001 inc, 010 add+cin, 011 a+(b>>>1), 100 and, 101 or, 110 concat, 111 LOAD imm
- instr_rd  in  2  destination register
- instr_ra  in  2  operand A register
- instr_rb  in  2  operand B register
- instr_cin  in  1  carry-in for opc 010
- instr_imm  in  16  immediate for LOAD
- alu_opc  out  3  to ALU opcode
- alu_ina  out  16  to ALU operand A
- alu_inb  out  16  to ALU operand B
- alu_inc  out  1  to ALU carry-in
- alu_w  in  16  ALU result
- alu_zer  in  1  ALU zero flag
- alu_neg  in  1  ALU negative flag
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  16  result written to rd
- rsp_zer  out  1  zero flag of result
- rsp_neg  out  1  negative flag of result
- dbg_addr  in  2  register-file read address
- dbg_data  out  16  combinational R[dbg_addr]
- err  out  1  sticky self-check error (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): state=IDLE; R[0..3]=0; alu_opc/ina/inb/inc=0; rsp_valid=0; rsp_data=0; rsp_zer=0; rsp_neg=0; err=0. An instruction in flight is discarded; no response is produced.
- FSM states: IDLE, EXEC, RESP.
- IDLE: instr_ready=1. On instr_valid&&instr_ready at edge T:
  - register alu_opc=instr_opc, alu_ina=R[ra], alu_inb=R[rb], alu_inc=(opc==010)?instr_cin:0, plus rd and imm;
  - go to EXEC.
- EXEC (cycle T+1): ALU inputs stable. At edge T+2:
  - non-LOAD: R[rd]<=alu_w; rsp_data<=alu_w; rsp_zer<=alu_zer; rsp_neg<=alu_neg.
  - LOAD (111): ALU result ignored; R[rd]<=imm; rsp_data<=imm; rsp_zer<=(imm==0); rsp_neg<=imm[15].
  - rsp_valid<=1; go to RESP.
- RESP: rsp_valid=1 with rsp_* held stable until rsp_valid&&rsp_ready at an edge; then rsp_valid<=0 and go to IDLE. Earliest next accept is the following edge.
  - Minimum accept-to-accept spacing is 3 cycles; accept-to-rsp_valid latency is 2 cycles.
- alu_* outputs hold their last values outside EXEC.
- Operands are snapshotted at accept. rd==ra or rd==rb is legal; the old value is used.
- Register-file write occurs only at EXEC→RESP. dbg_data reflects the write from the following cycle.
- instr_* is sampled only on handshake; the source may change it freely otherwise.

Optional Feature:
- Macro ALU_SEQ_CHECK_EN.
- Defined: an internal reference model computes the expected w from the snapshotted operands:
  - 000: ~a+1
  - 001: a+1
  - 010: a+b+cin
  - 011: a+(signed b>>>1)
  - 100: a&b
  - 101: a|b
  - 110: {a[7:0],b[7:0]}
  - The model wraps modulo 2^16.
- At the end of EXEC (non-LOAD) it compares alu_w, alu_zer and alu_neg against the expected values. Any mismatch sets err=1, sticky until reset.
- Not defined: err tied to 0; no model logic is generated.

Decomposition:
- Package alu_seq_pkg: opcode localparams (OPC_NEG..OPC_CONCAT, OPC_LOAD=3'b111), state enum {IDLE,EXEC,RESP}, W, NREG.
- One sub-module: alu_seq_regfile (4x16, one synchronous write port, two combinational read ports plus the dbg read port, async reset to 0).

Test Plan:
- LOAD R0=0x1234, R1=0x00FF; then add rd=R2 (ra=0, rb=1, cin=1) -> rsp_data=0x1334, zer=0, neg=0; dbg R2=0x1334; rsp_valid exactly 2 cycles after accept.
- LOAD R3=0x0001; opc 000 ra=3 -> 0xFFFF, neg=1. LOAD R3=0x0000; opc 000 -> 0x0000, zer=1.
- R0=0x0010, R1=0x8004; opc 011 -> 0xC012, neg=1. opc 110 with R0=0x1234, R1=0x00FF -> 0x34FF.
- Hold rsp_ready=0 for 5 cycles with instr_valid=1 -> rsp_* stable, instr_ready=0 throughout. Release -> one accept follows 1 cycle later.
- Assert rst_n=0 during EXEC -> all outputs at reset values, R[*]=0, no rsp_valid after release.
- With ALU_SEQ_CHECK_EN, a bench ALU model returns 0xDEAD for an add -> err=1 and stays 1. Without the macro, err=0.
